decode_hazard_ctrl: RTL and testbench
=====================================

DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating event counters.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction word held when the stage is empty.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_valid  in  1  fetch presents an instruction.
REQ-006 if_pc  in  32  PC of the presented instruction.
REQ-007 if_instr  in  32  presented instruction word.
REQ-008 id_ready  out  1  stage accepts the fetch word this cycle.
REQ-009 id_pc  out  32  registered PC of the held instruction.
REQ-010 id_instr  out  32  registered instruction word, driven to the immediate generator and register file.
REQ-011 ex_valid  out  1  held instruction is offered to EX.
REQ-012 ex_ready  in  1  EX accepts the offer this cycle.
REQ-013 ex_is_load  in  1  the instruction currently in EX is a load.
REQ-014 ex_rd  in  5  destination register of the instruction in EX.
REQ-015 flush  in  1  taken branch or jump resolved in EX; kill the decode-stage contents.
REQ-016 hazard_stall  out  1  a load-use bubble is inserted this cycle.
REQ-017 stall_cnt  out  CNT_W  count of bubble cycles, saturating.
REQ-018 flush_cnt  out  CNT_W  count of flush cycles that killed a valid instruction, saturating.

Function
REQ-019 The FSM SHALL have two states: EMPTY (no valid instruction held) and FULL (instruction held).
REQ-020 Source-register usage SHALL be decoded from id_instr[6:0] as follows:
- 0110011, 0100011, 1100011: uses rs1 [19:15] and rs2 [24:20].
- 0010011, 0000011, 1100111: uses rs1 only.
- All other opcodes: uses neither.
REQ-021 The hazard term SHALL be FULL & ex_is_load & ex_rd!=0 & (ex_rd==used rs1 | ex_rd==used rs2) & ~flush.
REQ-022 Outputs SHALL be combinational from state and inputs:
- hazard_stall = hazard.
- ex_valid = FULL & ~hazard & ~flush.
- id_ready = flush | EMPTY | (ex_valid & ex_ready).
REQ-023 A transfer SHALL occur when ex_valid & ex_ready; a capture SHALL occur when if_valid & id_ready & ~flush.
REQ-024 Capture SHALL load if_pc and if_instr into id_pc and id_instr and enter FULL.
REQ-025 EMPTY: on capture go to FULL; otherwise stay EMPTY with id_instr = NOP_INSTR.
REQ-026 FULL with transfer: on capture in the same cycle stay FULL with the new word (zero-bubble back-to-back); with no capture go to EMPTY and load id_instr = NOP_INSTR.
REQ-027 FULL without transfer (hazard or ~ex_ready): hold id_pc and id_instr unchanged, and keep id_ready=0.
REQ-028 Flush SHALL take priority over every other event:
- Next state is EMPTY, id_instr = NOP_INSTR, id_pc = 0.
- Any if_valid word in the same cycle SHALL be discarded, with id_ready=1.
REQ-029 A hazard SHALL be re-evaluated every cycle; the bubble SHALL persist while it holds, and the instruction SHALL issue in the first cycle it clears and ex_ready=1.
REQ-030 stall_cnt SHALL increment by 1 each cycle hazard_stall=1 and hold at 2^CNT_W-1.
REQ-031 flush_cnt SHALL increment by 1 each cycle flush=1 while FULL and hold at 2^CNT_W-1.
REQ-032 The hazard term SHALL ignore register x0 (ex_rd==0 never stalls).
REQ-033 Latency: an instruction captured in cycle N SHALL be offered (ex_valid=1) in cycle N+1 absent hazard and flush.

Reset
REQ-034 While rst=1, the block SHALL immediately, independent of clk, enter EMPTY with:
- id_pc=0 and id_instr=NOP_INSTR.
- stall_cnt=0 and flush_cnt=0.
- ex_valid=0 and hazard_stall=0.
REQ-035 Reset asserted mid-operation SHALL discard the held instruction; the first capture SHALL occur on the first rising edge after rst deasserts with if_valid=1.

Verification
REQ-036 Streaming: if_valid=1 and ex_ready=1 for 4 cycles with instrs A..D -> ex_valid=1 from cycle 1, id_instr=A,B,C,D on consecutive cycles, no bubbles.
REQ-037 Load-use hazard:
- Stimulus: hold 0x00208133 (add x2,x1,x2) with ex_is_load=1 and ex_rd=1 for one cycle.
- Response: hazard_stall=1, ex_valid=0, id_ready=0, stall_cnt=1.
- Next cycle, with ex_is_load=0: ex_valid=1 with the same word.
REQ-038 No false stall: hold LUI 0x000010b7 with ex_is_load=1 and ex_rd=1 -> hazard_stall=0; ex_rd=0 with any opcode -> hazard_stall=0.
REQ-039 Flush: FULL with if_valid=1 and flush=1 -> next cycle EMPTY, id_instr=0x00000013, fetch word dropped, flush_cnt=1.
REQ-040 Backpressure: FULL with ex_ready=0 for 3 cycles -> id_pc and id_instr stable, id_ready=0; on ex_ready=1, a transfer and a capture occur in the same cycle.
REQ-041 Saturation and reset:
- CNT_W=2 with 5 hazard cycles -> stall_cnt=3.
- Asserting rst between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl
//
// Purpose: instruction-decode stage holding register with valid/ready
// handshakes toward fetch and execute. It inserts a one-cycle bubble per
// cycle while a load in EX writes a source register of the held
// instruction. It kills the held instruction on a branch/jump flush. It also
// keeps saturating counters of bubble cycles and of flushes that killed a
// valid instruction.
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   if_valid      - fetch presents if_pc / if_instr
//   if_pc         - PC of the presented instruction
//   if_instr      - presented instruction word
//   id_ready      - stage accepts the fetch word this cycle
//   id_pc         - registered PC of the held instruction
//   id_instr      - registered instruction word (NOP_INSTR when empty)
//   ex_valid      - held instruction is offered to EX
//   ex_ready      - EX accepts the offer this cycle
//   ex_is_load    - instruction currently in EX is a load
//   ex_rd         - destination register of the instruction in EX
//   flush         - taken branch/jump resolved in EX, kill decode contents
//   hazard_stall  - load-use bubble inserted this cycle
//   stall_cnt     - saturating count of bubble cycles
//   flush_cnt     - saturating count of flushes that killed a valid word

module decode_hazard_ctrl #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             ex_valid,
  input  logic             ex_ready,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_full;
  logic       hazard;
  logic       transfer;
  logic       capture;

  assign opcode  = id_instr[6:0];
  assign rs1     = id_instr[19:15];
  assign rs2     = id_instr[24:20];
  assign is_full = (state == FULL);

  // Source-register usage by opcode. R-type, store and branch read both
  // sources. OP-IMM, load and JALR read rs1 only. Everything else (LUI,
  // AUIPC, JAL, system, ...) reads none, so stray bits in those fields
  // never cause a false stall.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 is hardwired to zero, so a load targeting it can never create a
  // real dependency.
  assign hazard = is_full && ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2))) &&
                  !flush;

  assign hazard_stall = hazard;
  assign ex_valid     = is_full && !hazard && !flush;
  assign id_ready     = flush || !is_full || (ex_valid && ex_ready);
  assign transfer     = ex_valid && ex_ready;
  // A flush raises id_ready but the fetched word is wrong-path, so it is
  // excluded from capture.
  assign capture      = if_valid && id_ready && !flush;

  // Stage register and counters. Flush wins over everything. A capture
  // (alone or together with a transfer) refills the stage. A transfer
  // without a capture empties it. Otherwise the word is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      id_pc     <= 32'd0;
      id_instr  <= NOP_INSTR;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush) begin
        state    <= EMPTY;
        id_pc    <= 32'd0;
        id_instr <= NOP_INSTR;
      end else if (capture) begin
        state    <= FULL;
        id_pc    <= if_pc;
        id_instr <= if_instr;
      end else if (transfer) begin
        state    <= EMPTY;
        id_instr <= NOP_INSTR;
      end

      if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (flush && is_full && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl
//
// Directed self-checking bench for decode_hazard_ctrl. It drives a
// default-width instance and a CNT_W=2 instance from the same stimulus. The
// second instance exercises counter saturation.

module tb_decode_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;

  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        ex_valid;
  logic        hazard_stall;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        sat_id_ready;
  logic [31:0] sat_id_pc;
  logic [31:0] sat_id_instr;
  logic        sat_ex_valid;
  logic        sat_hazard_stall;
  logic [1:0]  sat_stall_cnt;
  logic [1:0]  sat_flush_cnt;

  int total;
  int bad;

  decode_hazard_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  decode_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .id_ready     (sat_id_ready),
    .id_pc        (sat_id_pc),
    .id_instr     (sat_id_instr),
    .ex_valid     (sat_ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .hazard_stall (sat_hazard_stall),
    .stall_cnt    (sat_stall_cnt),
    .flush_cnt    (sat_flush_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and report a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                               input logic er, input logic ld, input logic [4:0] rd,
                               input logic fl);
    if_valid   = iv;
    if_pc      = pc;
    if_instr   = instr;
    ex_ready   = er;
    ex_is_load = ld;
    ex_rd      = rd;
    flush      = fl;
    #1;
  endtask

  // Advance to just past the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;

    // Reset state.
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_instr", id_instr, NOP);
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    checkOutput("rst_id_ready", {31'd0, id_ready}, 32'd1);

    tick();
    rst = 1'b0;
    tick();

    // Streaming four instructions with no bubbles.
    applyStimulus(1'b1, 32'h100, 32'h0050_0113, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("str0_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("str0_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h104, 32'h0060_0193, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("str1_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("str1_id_instr", id_instr, 32'h0050_0113);
    checkOutput("str1_id_pc", id_pc, 32'h100);
    checkOutput("str1_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h108, 32'h0070_0213, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("str2_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("str2_id_instr", id_instr, 32'h0060_0193);
    tick();
    applyStimulus(1'b1, 32'h10c, 32'h0080_0293, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("str3_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("str3_id_instr", id_instr, 32'h0070_0213);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("str4_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("str4_id_instr", id_instr, 32'h0080_0293);
    checkOutput("str4_id_pc", id_pc, 32'h10c);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("drain_id_instr", id_instr, NOP);
    checkOutput("drain_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Load-use hazard on add x2,x1,x2 (rs1=x1, rs2=x2).
    applyStimulus(1'b1, 32'h200, 32'h0020_8133, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
    checkOutput("lu_rs1_hazard", {31'd0, hazard_stall}, 32'd1);
    checkOutput("lu_rs1_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_rs1_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
    checkOutput("lu_stall_cnt1", {16'd0, stall_cnt}, 32'd1);
    checkOutput("lu_rs2_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd2, 1'b0);
    checkOutput("lu_clear_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("lu_clear_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_clear_id_instr", id_instr, 32'h0020_8133);
    checkOutput("lu_stall_cnt2", {16'd0, stall_cnt}, 32'd2);
    tick();

    // No false stall: LUI reads no registers.
    applyStimulus(1'b1, 32'h300, 32'h0000_10b7, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
    checkOutput("lui_no_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("lui_ex_valid", {31'd0, ex_valid}, 32'd1);
    // addi x1,x0,1 reads x0; a load to x0 must not stall it.
    applyStimulus(1'b1, 32'h308, 32'h0010_0093, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h30c, 32'h0020_0113, 1'b0, 1'b1, 5'd0, 1'b0);
    checkOutput("x0_no_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("x0_ex_valid", {31'd0, ex_valid}, 32'd1);

    // Backpressure: three cycles of ex_ready=0 hold the word.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h30c, 32'h0020_0113, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("bp_id_ready", {31'd0, id_ready}, 32'd0);
      checkOutput("bp_id_pc", id_pc, 32'h308);
      checkOutput("bp_id_instr", id_instr, 32'h0010_0093);
      tick();
    end
    applyStimulus(1'b1, 32'h30c, 32'h0020_0113, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("bp_release_id_ready", {31'd0, id_ready}, 32'd1);
    checkOutput("bp_release_ex_valid", {31'd0, ex_valid}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h400, 32'h0030_0193, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("bp_new_id_pc", id_pc, 32'h30c);
    checkOutput("bp_new_id_instr", id_instr, 32'h0020_0113);

    // Flush while FULL with a fetch word present.
    checkOutput("fl_id_ready", {31'd0, id_ready}, 32'd1);
    checkOutput("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("fl_id_instr", id_instr, NOP);
    checkOutput("fl_id_pc", id_pc, 32'd0);
    checkOutput("fl_ex_valid_after", {31'd0, ex_valid}, 32'd0);
    checkOutput("fl_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    // Flush while EMPTY does not count.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("fl_empty_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Saturation: five more hazard cycles. The CNT_W=2 copy starts at 2.
    applyStimulus(1'b1, 32'h500, 32'h0020_8133, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
      tick();
      checkOutput("sat_stall_cnt", {30'd0, sat_stall_cnt}, (2 + i > 3) ? 32'd3 : 32'(2 + i));
      checkOutput("wide_stall_cnt", {16'd0, stall_cnt}, 32'(2 + i));
    end

    // Reset between edges while FULL and stalled.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_id_pc", id_pc, 32'd0);
    checkOutput("mid_rst_id_instr", id_instr, NOP);
    checkOutput("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("mid_rst_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("mid_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h600, 32'h0040_0213, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("post_rst_id_pc", id_pc, 32'h600);
    checkOutput("post_rst_ex_valid", {31'd0, ex_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
